// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial add/subtract sequencer sharing one full_adder cell, with optional saturation
module full_adder (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic carry, sat_r, sign_a, sign_b, s, co, v, last;
  logic [WIDTH-1:0] opa, opb, sreg, raw, fin, bx;
  full_adder u_fa (.cout(co), .sum(s), .a(opa[0]), .b(opb[0]), .cin(carry));
  always_comb begin
    bx   = sub ? ~b : b;
    last = cnt == CW'(WIDTH - 1);
    raw  = {s, sreg[WIDTH-1:1]};
    v    = (sign_a == sign_b) && (raw[WIDTH-1] != sign_a);
    fin  = (sat_r && v) ? {sign_a, {(WIDTH-1){~sign_a}}} : raw;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovfl   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      sreg   <= '0;
      sat_r  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (state != RUN && start) begin
      opa    <= a;
      opb    <= bx;
      carry  <= sub;
      sat_r  <= sat;
      sign_a <= a[WIDTH-1];
      sign_b <= bx[WIDTH-1];
      cnt    <= '0;
      state  <= RUN;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (state == DONE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (state == RUN) begin
      sreg  <= raw;
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= co;
      cnt   <= last ? cnt : cnt + 1'b1;
      if (last) begin
        result <= fin;
        ovfl   <= v;
        zero   <= fin == '0;
        neg    <= fin[WIDTH-1];
        state  <= DONE;
        done   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed and swept checks of serial_add_seq against a signed-arithmetic model
module tb_serial_add_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, sat = 1'b0;
  logic [15:0] a = '0, b = '0, result;
  logic busy, done, ovfl, zero, neg;
  int checks = 0, errors = 0;

  serial_add_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub), .sat(sat),
    .busy(busy), .done(done), .result(result), .ovfl(ovfl), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_op(input logic [15:0] x, input logic [15:0] y, input logic s, input logic t);
    int r;
    logic v;
    r = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    v = r > 32767 || r < -32768;
    return {v, (t && v) ? (r < 0 ? 16'h8000 : 16'h7fff) : r[15:0]};
  endfunction

  // model: an accepted op is busy for 16 cycles, then shows its result with done on the 17th
  int ph = 0;
  logic men = 1'b0, ps = 1'b0, pt = 1'b0, mo = 1'b0, mz = 1'b0, mn = 1'b0;
  logic [15:0] pa = '0, pb = '0, mr = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      ph <= 0; mr <= '0; mo <= 1'b0; mz <= 1'b0; mn <= 1'b0; men <= 1'b1;
    end else if ((ph == 0 || ph == 17) && start) begin
      ph <= 1; pa <= a; pb <= b; ps <= sub; pt <= sat;
    end else if (ph == 17) begin
      ph <= 0;
    end else if (ph == 16) begin
      ph <= 17;
      {mo, mr} <= ref_op(pa, pb, ps, pt);
      mz <= ref_op(pa, pb, ps, pt) == 17'h0 || ref_op(pa, pb, ps, pt) == 17'h10000;
      mn <= ref_op(pa, pb, ps, pt) >> 15 & 17'h1;
    end else if (ph > 0) begin
      ph <= ph + 1;
    end
  end

  always @(negedge clk) if (men) begin
    cmp("m_busy", busy, ph > 0);
    cmp("m_done", done, ph == 17);
    cmp("m_result", result, mr);
    cmp("m_ovfl", ovfl, mo);
    cmp("m_zero", zero, mz);
    cmp("m_neg", neg, mn);
  end

  task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_, input logic ts, input logic tt,
                        input logic [15:0] er, input logic eo, input logic ez, input logic en);
    int k, nb;
    @(posedge clk); #1;
    a = ta; b = tb_; sub = ts; sat = tt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); sat = 1'($urandom);
    nb = int'(busy);
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5 && nm == "ignored") begin start = 1'b1; a = 16'hffff; b = 16'hffff; end
      if (k == 6) start = 1'b0;
      nb += int'(busy);
      if (done) break;
    end
    cmp({nm, "_latency"}, k, 16);
    cmp({nm, "_busy_cycles"}, nb, 17);
    cmp({nm, "_result"}, result, er);
    cmp({nm, "_ovfl"}, ovfl, eo);
    cmp({nm, "_zero"}, zero, ez);
    cmp({nm, "_neg"}, neg, en);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] edges [5] = '{16'h0000, 16'h0001, 16'h7fff, 16'h8000, 16'hffff};
    return ($urandom_range(3) == 0) ? edges[$urandom_range(4)] : 16'($urandom);
  endfunction

  initial begin
    int k, nd;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp("reset_busy", busy, 0);
    cmp("reset_result", result, 0);
    cmp("reset_done", done, 0);
    run_op("add1", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 0);
    run_op("ovf_nosat", 16'h7fff, 16'h0001, 0, 0, 16'h8000, 1, 0, 1);
    run_op("ovf_sat", 16'h7fff, 16'h0001, 0, 1, 16'h7fff, 1, 0, 0);
    run_op("sub_sat", 16'h8000, 16'h0001, 1, 1, 16'h8000, 1, 0, 1);
    run_op("sub_zero", 16'h0005, 16'h0005, 1, 0, 16'h0000, 0, 1, 0);
    run_op("ignored", 16'h1234, 16'h0111, 0, 0, 16'h1345, 0, 0, 0);
    // back-to-back: start held high; second operands already on the bus at the DONE cycle
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0005; sub = 1'b1; sat = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h8000; sub = 1'b0;
    for (k = 1; k <= 40; k++) begin @(posedge clk); #1; if (done) break; end
    cmp("b2b_first_latency", k, 16);
    cmp("b2b_first_result", result, 16'hfffe);
    cmp("b2b_first_neg", neg, 1);
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (done) break;
    end
    cmp("b2b_gap", k, 17);
    cmp("b2b_second_result", result, 16'h0000);
    cmp("b2b_second_ovfl", ovfl, 1);
    cmp("b2b_second_zero", zero, 1);
    // reset during RUN cycle 8 aborts
    @(posedge clk); #1;
    a = 16'h0100; b = 16'h0200; sub = 1'b0; sat = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cmp("abort_busy", busy, 0);
    cmp("abort_result", result, 0);
    nd = 0;
    repeat (40) begin @(posedge clk); #1; nd += int'(done); end
    cmp("abort_no_done", nd, 0);
    cmp("abort_result_held", result, 0);
    // sweep: start held high, operands change every cycle, checked by the model
    start = 1'b1;
    repeat (2000 * 17) begin
      @(posedge clk); #1;
      a = pick(); b = pick(); sub = 1'($urandom); sat = 1'($urandom);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
